uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_rcv.sv | 185 ++++++++++++++++++
 tb/tb_uart_rcv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Macro UART_RCV_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DFLT = 2604;
  localparam int unsigned CNT_W         = 12;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RCV_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter that times bit periods; terminal count is the value 1.
// It saturates at 0, so it never wraps while the receiver sits idle.
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_rcv.sv
// 8-bit UART receiver: synchronizer, start/data/stop FSM, mid-bit sampling.
// Define UART_RCV_PARITY_EN for a 9th even-parity bit and the par_err pulse.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       par_err,
  output state_t     state_o
);

  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_DIV / 2);

  logic sync1_q, sync2_q, sync3_q;
  logic fall_edge;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdy_q, rdy_d;
  logic       frm_q, frm_d;
  logic       par_ok;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_tc;

  // Resets to 1 so a line that is idle through reset does not look like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fall_edge = sync3_q & ~sync2_q;

  uart_baud_cnt u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

`ifdef UART_RCV_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_q, par_d;
  assign par_ok  = ~par_bad_q;
  assign par_err = par_q;
`else
  assign par_ok  = 1'b1;
  assign par_err = 1'b0;
`endif

  // rdy/clr_rdy: rdy holds a byte until clr_rdy or the next frame's START->DATA;
  // a set in the same cycle as clr_rdy wins.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q & ~clr_rdy;
    frm_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = FULL_LD;
    cnt_en    = (state_q != IDLE);
`ifdef UART_RCV_PARITY_EN
    par_bad_d = par_bad_q;
    par_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d  = START;
          cnt_load = 1'b1;
          cnt_val  = HALF_LD;
        end
      end
      START: begin
        if (cnt_tc) begin
          if (!sync2_q) begin
            state_d   = DATA;
            cnt_load  = 1'b1;
            bit_cnt_d = 4'd0;
            rdy_d     = 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_tc) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_load  = 1'b1;
          if (bit_cnt_q == 4'd7) begin
`ifdef UART_RCV_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RCV_PARITY_EN
      PARITY: begin
        if (cnt_tc) begin
          par_bad_d = (sync2_q != (^shift_q));
          par_d     = par_bad_d;
          cnt_load  = 1'b1;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_tc) begin
          state_d = IDLE;
          if (!sync2_q) begin
            frm_d = 1'b1;
          end else if (par_ok) begin
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
    end
  end

`ifdef UART_RCV_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_q     <= par_d;
    end
  end
`endif

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv: fast instance for framing, slow default instance
// for the start-glitch case. Honours UART_RCV_PARITY_EN when defined.
module tb_uart_rcv;
  import uart_pkg::*;

  localparam int D      = 16;
  localparam int H      = D / 2;
`ifdef UART_RCV_PARITY_EN
  localparam int L      = 2 + H + 10 * D;
  localparam int NV     = 8;
`else
  localparam int L      = 2 + H + 9 * D;
  localparam int NV     = 6;
`endif
  localparam int SLOW_H = BAUD_DIV_DFLT / 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx = 1'b1, clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, par_err;
  state_t     state;

  logic       rx_s = 1'b1, clr_s = 1'b0;
  logic [7:0] rx_data_s;
  logic       rdy_s, frm_s, par_s;
  state_t     state_s;

  uart_rcv #(.BAUD_DIV(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .par_err(par_err),
    .state_o(state)
  );

  uart_rcv u_slow (
    .clk(clk), .rst_n(rst_n), .RX(rx_s), .clr_rdy(clr_s),
    .rx_data(rx_data_s), .rdy(rdy_s), .frm_err(frm_s), .par_err(par_s),
    .state_o(state_s)
  );

  // event monitor
  int     rise_cyc = -1, fall_cyc = -1;
  state_t fall_state = IDLE;
  logic   rdy_prev = 1'b0;
  int     frm_cnt = 0, par_cnt = 0, slow_rdy_cnt = 0, slow_frm_cnt = 0;

  always @(negedge clk) begin
    if (rdy && !rdy_prev) rise_cyc = cyc;
    if (!rdy && rdy_prev) begin
      fall_cyc   = cyc;
      fall_state = state;
    end
    rdy_prev = rdy;
    if (frm_err) frm_cnt++;
    if (par_err) par_cnt++;
    if (rdy_s) slow_rdy_cnt++;
    if (frm_s) slow_frm_cnt++;
  end

  // scoreboard counters
  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // drivers
  int t_start = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc + 1;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(D);
    end
`ifdef UART_RCV_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(D);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_b;
    tick(D);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       par_flip;
    logic       exp_rdy;
    logic [7:0] exp_data;
    int         exp_frm;
    int         exp_par;
  } vec_t;

  vec_t vecs[NV];
  int   c_s, c_i;

  initial begin
    vecs[0] = '{CMD_GO,   1'b1, 1'b0, 1'b1, CMD_GO,   0, 0};
    vecs[1] = '{CMD_STOP, 1'b1, 1'b0, 1'b1, CMD_STOP, 0, 0};
    vecs[2] = '{8'h55,    1'b0, 1'b0, 1'b0, CMD_STOP, 1, 0};
    vecs[3] = '{8'h00,    1'b1, 1'b0, 1'b1, 8'h00,    0, 0};
    vecs[4] = '{8'hFF,    1'b1, 1'b0, 1'b1, 8'hFF,    0, 0};
    vecs[5] = '{8'hA5,    1'b1, 1'b0, 1'b1, 8'hA5,    0, 0};
`ifdef UART_RCV_PARITY_EN
    vecs[6] = '{CMD_GO,   1'b1, 1'b1, 1'b0, 8'hA5,    0, 1};
    vecs[7] = '{CMD_GO,   1'b1, 1'b0, 1'b1, CMD_GO,   0, 0};
`endif

    // reset state
    tick(3);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_frm", 32'(frm_err), 0);
    check("rst_par", 32'(par_err), 0);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_slow_state", 32'(state_s), 32'(IDLE));
    rst_n = 1'b1;
    tick(5);

    // start glitch on the default-rate instance: 500 low cycles
    fork
      begin
        rx_s = 1'b0;
        tick(500);
        rx_s = 1'b1;
      end
      begin
        for (int k = 0; k < 20 && state_s != START; k++) @(negedge clk);
        c_s = cyc;
        check("glitch_enter_start", 32'(state_s), 32'(START));
        for (int k = 0; k < 3000 && state_s != IDLE; k++) @(negedge clk);
        c_i = cyc;
        check("glitch_back_idle", 32'(state_s), 32'(IDLE));
        check("glitch_start_dwell", 32'(c_i - c_s), 32'(SLOW_H));
      end
    join
    tick(10);
    check("glitch_no_rdy", 32'(slow_rdy_cnt), 0);
    check("glitch_no_frm", 32'(slow_frm_cnt), 0);
    check("glitch_data", 32'(rx_data_s), 0);

    // vector table
    for (int i = 0; i < NV; i++) begin
      pulse_clr();
      check($sformatf("v%0d_clr", i), 32'(rdy), 0);
      frm_cnt = 0;
      par_cnt = 0;
      rise_cyc = -1;
      send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].par_flip);
      tick(4);
      check($sformatf("v%0d_rdy", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("v%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_frm", i), 32'(frm_cnt), 32'(vecs[i].exp_frm));
      check($sformatf("v%0d_par", i), 32'(par_cnt), 32'(vecs[i].exp_par));
      check($sformatf("v%0d_state", i), 32'(state), 32'(IDLE));
      if (vecs[i].exp_rdy) check($sformatf("v%0d_latency", i), 32'(rise_cyc - t_start), 32'(L));
    end

    // back-to-back CMD_STOP then CMD_GO, clr_rdy lands on the set cycle
    frm_cnt = 0;
    send_frame(CMD_STOP, 1'b1, 1'b0);
    check("b2b_first_rdy", 32'(rdy), 1);
    check("b2b_first_data", 32'(rx_data), 32'(CMD_STOP));
    rise_cyc = -1;
    fall_cyc = -1;
    fork
      send_frame(CMD_GO, 1'b1, 1'b0);
      begin
        @(negedge clk);
        #1;
        while (cyc < t_start + L - 1) @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    tick(2);
    check("b2b_fall_cycle", 32'(fall_cyc - t_start), 32'(H + 2));
    check("b2b_fall_state", 32'(fall_state), 32'(DATA));
    check("b2b_rise_cycle", 32'(rise_cyc - t_start), 32'(L));
    check("b2b_rdy_set_wins", 32'(rdy), 1);
    check("b2b_data", 32'(rx_data), 32'(CMD_GO));
    check("b2b_frm", 32'(frm_cnt), 0);

    // reset in the middle of bit 4 of 0xA5, held to the end of that frame
    frm_cnt = 0;
    par_cnt = 0;
    rise_cyc = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(negedge clk);
        #1;
        while (cyc < t_start + 5 * D + H) @(negedge clk);
        rst_n = 1'b0;
        tick(3);
        check("midrst_rdy", 32'(rdy), 0);
        check("midrst_data", 32'(rx_data), 0);
        check("midrst_frm", 32'(frm_err), 0);
        check("midrst_par", 32'(par_err), 0);
        check("midrst_state", 32'(state), 32'(IDLE));
      end
    join
    rst_n = 1'b1;
    tick(4);
    check("midrst_no_rise", 32'(rise_cyc), 32'(-1));
    check("midrst_no_frm", 32'(frm_cnt), 0);
    rise_cyc = -1;
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(4);
    check("post_rst_rdy", 32'(rdy), 1);
    check("post_rst_data", 32'(rx_data), 32'h3C);
    check("post_rst_latency", 32'(rise_cyc - t_start), 32'(L));
    check("post_rst_frm", 32'(frm_cnt), 0);
    check("post_rst_par", 32'(par_cnt), 0);

    // plain acknowledge
    pulse_clr();
    check("clr_rdy_only", 32'(rdy), 0);
    check("clr_keeps_data", 32'(rx_data), 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
